// File: rtl/dmem_responder.sv
// Load/store data-memory responder: one request per handshake, optional wait states, byte-lane
// steering and load extension. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              busy
);

  localparam int LANES   = DATA_W / 8;
  localparam int DEPTH   = (2 ** ADDR_W) / 4;
  localparam int WORD_AW = ADDR_W - 2;
  localparam bit DIRECT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       transfer;
  logic       commit;

  // Accepted request, held until its response has been delivered
  logic              q_wr, q_rd;
  logic [ADDR_W-1:0] q_addr;
  logic [2:0]        q_f3;
  logic [DATA_W-1:0] q_wdata;

  // Fields used at the commit edge
  logic              c_wr, c_rd;
  logic [ADDR_W-1:0] c_addr;
  logic [2:0]        c_f3;
  logic [DATA_W-1:0] c_wdata;

  logic [ADDR_W-1:0] eff_addr;
  logic [1:0]        size;
  logic              misalign, mis_err, illegal, c_err, do_write;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wlane;
  logic [WORD_AW-1:0] widx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] word_reg;

  logic       r_err, r_load;
  logic [2:0] r_f3;
  logic [1:0] r_off;

  assign req_ready = (state_reg == S_IDLE) || (state_reg == S_RESP);
  assign transfer  = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    resp_valid = 1'b0;
    busy       = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (transfer) begin
          if (DIRECT) begin
            state_next = S_RESP;
            commit     = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_reg == 4'd0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (transfer) begin
          if (DIRECT) begin
            state_next = S_RESP;
            commit     = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end else begin
          state_next = S_IDLE;
          busy       = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_wr    <= 1'b0;
      q_rd    <= 1'b0;
      q_addr  <= '0;
      q_f3    <= '0;
      q_wdata <= '0;
    end else if (transfer) begin
      q_wr    <= wr;
      q_rd    <= rd;
      q_addr  <= addr;
      q_f3    <= funct3;
      q_wdata <= wr_data;
    end
  end

  // Without wait states the access commits on the accepting edge, straight from the inputs
  assign c_wr    = DIRECT ? wr      : q_wr;
  assign c_rd    = DIRECT ? rd      : q_rd;
  assign c_addr  = DIRECT ? addr    : q_addr;
  assign c_f3    = DIRECT ? funct3  : q_f3;
  assign c_wdata = DIRECT ? wr_data : q_wdata;

  assign size     = c_f3[1:0];
  assign misalign = ((size == 2'b01) && c_addr[0]) || ((size == 2'b10) && (c_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign eff_addr = c_addr;
  assign mis_err  = misalign;
`else
  always_comb begin
    eff_addr = c_addr;
    if (size == 2'b01) eff_addr[0] = 1'b0;
    if (size == 2'b10) eff_addr[1:0] = 2'b00;
  end
  assign mis_err = 1'b0;
`endif

  always_comb begin
    illegal = 1'b0;
    if (c_wr && c_rd) begin
      illegal = 1'b1;
    end else if (c_wr) begin
      illegal = (c_f3 > 3'b010);
    end else if (c_rd) begin
      illegal = !((c_f3 == 3'b000) || (c_f3 == 3'b001) || (c_f3 == 3'b010) ||
                  (c_f3 == 3'b100) || (c_f3 == 3'b101));
    end
  end

  assign c_err    = illegal || ((c_wr || c_rd) && mis_err);
  // Gated by reset so a request presented during reset can never reach the array
  assign do_write = commit && c_wr && !c_err && reset;
  assign widx     = eff_addr[ADDR_W-1:2];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (size == 2'b00) ? (eff_addr[1:0] == LANE) :
                      (size == 2'b01) ? (eff_addr[1] == LANE[1]) : 1'b1;
      assign wlane[8*gi +: 8] = (size == 2'b00) ? c_wdata[7:0] :
                                (size == 2'b01) ? c_wdata[8*(gi%2) +: 8] :
                                                  c_wdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
    if (commit) word_reg <= mem[widx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err  <= 1'b0;
      r_load <= 1'b0;
      r_f3   <= '0;
      r_off  <= '0;
    end else if (commit) begin
      r_err  <= c_err;
      r_load <= c_rd && !c_wr && !c_err;
      r_f3   <= c_f3;
      r_off  <= eff_addr[1:0];
    end
  end

  logic [DATA_W-1:0] shifted, ext;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    shifted  = word_reg >> {r_off, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = r_off[1] ? word_reg[31:16] : word_reg[15:0];
    ext      = '0;
    case (r_f3)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  ext = word_reg;
      3'b100:  ext = {24'b0, byte_sel};
      3'b101:  ext = {16'b0, half_sel};
      default: ext = '0;
    endcase
  end

  assign rd_data = (resp_valid && r_load) ? ext : '0;
  assign err     = resp_valid && r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a vector table and a
// WAIT_CYCLES=0 instance for back-to-back traffic; also covers reset during a pending store.
module tb_dmem_responder;

  localparam int WAIT_A = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, wr, rd;
  logic [8:0]  addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  int          sel;
  int          cur_wait;

  logic        rv_a, rv_b;
  logic        ready_a, resp_a, err_a, busy_a;
  logic        ready_b, resp_b, err_b, busy_b;
  logic [31:0] data_a, data_b;

  logic        req_ready, resp_valid, err, busy;
  logic [31:0] rd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rv_a = req_valid && (sel == 0);
  assign rv_b = req_valid && (sel == 1);

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(ready_a), .wr(wr), .rd(rd),
    .addr(addr), .funct3(funct3), .wr_data(wr_data), .resp_valid(resp_a), .rd_data(data_a),
    .err(err_a), .busy(busy_a));

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(ready_b), .wr(wr), .rd(rd),
    .addr(addr), .funct3(funct3), .wr_data(wr_data), .resp_valid(resp_b), .rd_data(data_b),
    .err(err_b), .busy(busy_b));

  always_comb begin
    req_ready  = (sel == 0) ? ready_a : ready_b;
    resp_valid = (sel == 0) ? resp_a  : resp_b;
    err        = (sel == 0) ? err_a   : err_b;
    busy       = (sel == 0) ? busy_a  : busy_b;
    rd_data    = (sel == 0) ? data_a  : data_b;
  end

  typedef struct {
    logic        w;
    logic        r;
    logic [8:0]  a;
    logic [2:0]  f;
    logic [31:0] d;
    logic        ee;
    logic [31:0] ed;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic xact(input int idx, input logic w, input logic r, input logic [8:0] a,
                      input logic [2:0] f, input logic [31:0] d,
                      input logic ee, input logic [31:0] ed);
    int n;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    req_valid = 1'b1; wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
    chk($sformatf("vec%0d req_ready", idx), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request fields once accepted; the DUT must not look at them again
    req_valid = 1'b0; wr = 1'b1; rd = 1'b0; addr = ~a; funct3 = 3'b010; wr_data = 32'h5A5A5A5A;
    seen = 1'b0;
    busy_ok = 1'b1;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) n = 99;
    chk($sformatf("vec%0d latency", idx), 32'(n), 32'(1 + cur_wait));
    chk($sformatf("vec%0d busy", idx), 32'(busy_ok), 32'd1);
    chk($sformatf("vec%0d err", idx), 32'(err), 32'(ee));
    chk($sformatf("vec%0d rd_data", idx), rd_data, ed);
    $display("[TB] vec %0d wr=%0d rd=%0d addr=0x%03h f3=%03b wdata=0x%08h -> lat=%0d err=%0d rd_data=0x%08h",
             idx, w, r, a, f, d, n, err, rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 9'h013, 3'b000, 32'h00000080, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 9'h013, 3'b000, 32'h0, 1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1'b0, 1'b1, 9'h013, 3'b100, 32'h0, 1'b0, 32'h00000080};
    vecs[5]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, 32'h80ADBEEF};
    vecs[6]  = '{1'b1, 1'b0, 9'h012, 3'b001, 32'h00001234, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, 32'h1234BEEF};
    vecs[8]  = '{1'b0, 1'b1, 9'h012, 3'b001, 32'h0, 1'b0, 32'h00001234};
    vecs[9]  = '{1'b0, 1'b1, 9'h012, 3'b101, 32'h0, 1'b0, 32'h00001234};
    vecs[10] = '{1'b0, 1'b1, 9'h011, 3'b010, 32'h0, TRAP, TRAP ? 32'h0 : 32'h1234BEEF};
    vecs[11] = '{1'b1, 1'b1, 9'h010, 3'b010, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 9'h010, 3'b011, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, 32'h1234BEEF};
    vecs[14] = '{1'b0, 1'b1, 9'h010, 3'b011, 32'h0, 1'b1, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 9'h010, 3'b110, 32'h0, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 9'h010, 3'b010, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 9'h010, 3'b001, 32'h0, 1'b0, 32'hFFFFBEEF};
    vecs[18] = '{1'b1, 1'b0, 9'h011, 3'b000, 32'hAAAAAA55, 1'b0, 32'h0};
    vecs[19] = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, 32'h123455EF};
    vecs[20] = '{1'b0, 1'b1, 9'h011, 3'b101, 32'h0, TRAP, TRAP ? 32'h0 : 32'h000055EF};
    vecs[21] = '{1'b1, 1'b0, 9'h1FF, 3'b000, 32'h0000007F, 1'b0, 32'h0};
    vecs[22] = '{1'b0, 1'b1, 9'h1FF, 3'b000, 32'h0, 1'b0, 32'h0000007F};
    vecs[23] = '{1'b1, 1'b0, 9'h011, 3'b001, 32'h0000ABCD, TRAP, 32'h0};
    vecs[24] = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, TRAP ? 32'h123455EF : 32'h1234ABCD};

    sel = 0; cur_wait = WAIT_A;
    reset = 1'b0; req_valid = 1'b0; wr = 1'b0; rd = 1'b0;
    addr = '0; funct3 = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("reset req_ready_a", 32'(ready_a), 32'd1);
    chk("reset resp_valid_a", 32'(resp_a), 32'd0);
    chk("reset busy_a", 32'(busy_a), 32'd0);
    chk("reset err_a", 32'(err_a), 32'd0);
    chk("reset rd_data_a", data_a, 32'h0);
    chk("reset req_ready_b", 32'(ready_b), 32'd1);
    chk("reset resp_valid_b", 32'(resp_b), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      xact(i, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].f, vecs[i].d, vecs[i].ee, vecs[i].ed);
    end

    // Reset while a store is waiting: it must be dropped and the old word kept
    @(negedge clk);
    req_valid = 1'b1; wr = 1'b1; rd = 1'b0; addr = 9'h010; funct3 = 3'b010; wr_data = 32'h11111111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("midreset busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset resp_valid", 32'(resp_valid), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset req_ready", 32'(req_ready), 32'd1);
    chk("midreset err", 32'(err), 32'd0);
    chk("midreset rd_data", rd_data, 32'h0);
    $display("[TB] reset during WAIT store: busy=%0d req_ready=%0d resp_valid=%0d", busy, req_ready, resp_valid);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    xact(100, 1'b0, 1'b1, 9'h010, 3'b010, 32'h0, 1'b0, TRAP ? 32'h123455EF : 32'h1234ABCD);

    // Zero wait states: store then load on consecutive cycles
    sel = 1; cur_wait = 0;
    @(negedge clk);
    req_valid = 1'b1; wr = 1'b1; rd = 1'b0; addr = 9'h020; funct3 = 3'b010; wr_data = 32'hCAFEF00D;
    #1 chk("b2b sw req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    wr = 1'b0; rd = 1'b1; wr_data = 32'h0;
    #1;
    chk("b2b sw resp_valid", 32'(resp_valid), 32'd1);
    chk("b2b sw err", 32'(err), 32'd0);
    chk("b2b sw rd_data", rd_data, 32'h0);
    chk("b2b lw req_ready", 32'(req_ready), 32'd1);
    chk("b2b busy_with_new_req", 32'(busy), 32'd0);
    $display("[TB] b2b SW 0x020 resp_valid=%0d err=%0d req_ready=%0d busy=%0d", resp_valid, err, req_ready, busy);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("b2b lw resp_valid", 32'(resp_valid), 32'd1);
    chk("b2b lw rd_data", rd_data, 32'hCAFEF00D);
    chk("b2b lw busy", 32'(busy), 32'd1);
    $display("[TB] b2b LW 0x020 resp_valid=%0d rd_data=0x%08h busy=%0d", resp_valid, rd_data, busy);
    @(negedge clk);
    chk("b2b idle resp_valid", 32'(resp_valid), 32'd0);
    chk("b2b idle busy", 32'(busy), 32'd0);
    xact(200, 1'b0, 1'b1, 9'h022, 3'b001, 32'h0, 1'b0, 32'hFFFFCAFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
